// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                      |
// | Description : Shared constants and the MEM->WB payload struct for the      |
// |               19-bit pipelined CPU.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int CPU_DATA_W = 19;
    localparam int CPU_REG_AW = 3;

    // Field order matches the packing used on the MEM->WB boundary.
    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [CPU_DATA_W-1:0] rdata;
        logic [CPU_DATA_W-1:0] out;
        logic [CPU_REG_AW-1:0] rd;
    } mem_wb_t;

    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage
`default_nettype wire

// File: rtl/mem_wb_skid_pipe_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_skid                                                    |
// | Description : Generic two-entry ready/valid skid buffer with synchronous   |
// |               flush. in_ready is registered (no path from out_ready).      |
// | Ports       : clk, rst_n        - clock, async active-low reset            |
// |               flush             - drop held and incoming beats             |
// |               in_valid/in_ready/in_data    - upstream handshake            |
// |               out_valid/out_ready/out_data - downstream handshake          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_skid #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 main_valid_q, main_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
    logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
    logic                 w_accept;
    logic                 w_consume;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign w_accept  = in_valid && !skid_valid_q;
    assign w_consume = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Payloads deliberately hold; only the valid bits are killed.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && w_consume) begin
            // in_ready is low here, so no new beat can arrive this cycle.
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || w_consume) begin
            main_valid_d = w_accept;
            if (w_accept) begin
                main_data_d = in_data;
            end
        end else if (w_accept) begin
            // Main is stalled: park the beat; in_ready drops next cycle.
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_wb_skid                                                  |
// | Description : MEM->WB pipeline boundary with ready/valid handshake, 2-entry|
// |               skid buffer, synchronous flush, writeback data mux, write    |
// |               strobe and a saturating back-pressure cycle counter.         |
// | Ports       : clk, rst_n, flush                                            |
// |               mem_valid/mem_ready, mem_regwrite, mem_memtoreg, mem_rdata,  |
// |               mem_out, mem_rd          - MEM side beat                     |
// |               wb_valid/wb_ready, wb_regwrite, wb_memtoreg, wb_rdata,       |
// |               wb_out, wb_rd            - WB side registered beat           |
// |               wb_data, wb_we           - writeback value and strobe        |
// |               stall_cnt                - back-pressured cycle count        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_wb_skid
    import cpu_pkg::*;
#(
    parameter int DATA_W      = CPU_DATA_W,
    parameter int REG_AW      = CPU_REG_AW,
    parameter int ZERO_REG_RO = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_out,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W   = 2 + 2 * DATA_W + REG_AW;
    localparam bit ZERO_RO = (ZERO_REG_RO != 0);

    logic [PAY_W-1:0] w_in_data;
    logic [PAY_W-1:0] w_out_data;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign w_in_data = {mem_regwrite, mem_memtoreg, mem_rdata, mem_out, mem_rd};

    pipe_skid #(
        .PAYLOAD_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (mem_valid),
        .in_ready  (mem_ready),
        .in_data   (w_in_data),
        .out_valid (wb_valid),
        .out_ready (wb_ready),
        .out_data  (w_out_data)
    );

    assign {wb_regwrite, wb_memtoreg, wb_rdata, wb_out, wb_rd} = w_out_data;

    assign wb_data = wb_memtoreg ? wb_rdata : wb_out;
    assign wb_we   = wb_valid && wb_regwrite && wb_ready
                     && !(ZERO_RO && (wb_rd == '0));

    // Counts cycles where WB holds a beat but refuses it; saturates, no wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wb_valid && !wb_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_wb_skid                                               |
// | Description : Self-checking bench for mem_wb_skid. Two instances share the |
// |               stimulus: dut_a (ZERO_REG_RO=0, CNT_W=16) and dut_b          |
// |               (ZERO_REG_RO=1, CNT_W=4). A queue-based model predicts both. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_wb_skid;
    import cpu_pkg::*;

    localparam int DW = 19;
    localparam int AW = 3;

    logic    clk       = 1'b0;
    logic    rst_n     = 1'b0;
    logic    flush     = 1'b0;
    logic    mem_valid = 1'b0;
    logic    wb_ready  = 1'b0;
    mem_wb_t in_beat   = '0;

    logic          a_mem_ready, a_wb_valid, a_wb_regwrite, a_wb_memtoreg, a_wb_we;
    logic [DW-1:0] a_wb_rdata, a_wb_out, a_wb_data;
    logic [AW-1:0] a_wb_rd;
    logic [15:0]   a_cnt;
    logic          b_mem_ready, b_wb_valid, b_wb_regwrite, b_wb_memtoreg, b_wb_we;
    logic [DW-1:0] b_wb_rdata, b_wb_out, b_wb_data;
    logic [AW-1:0] b_wb_rd;
    logic [3:0]    b_cnt;

    always #5 clk = ~clk;

    mem_wb_skid #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG_RO(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(a_mem_ready),
        .mem_regwrite(in_beat.regwrite), .mem_memtoreg(in_beat.memtoreg),
        .mem_rdata(in_beat.rdata), .mem_out(in_beat.out), .mem_rd(in_beat.rd),
        .wb_valid(a_wb_valid), .wb_ready(wb_ready),
        .wb_regwrite(a_wb_regwrite), .wb_memtoreg(a_wb_memtoreg),
        .wb_rdata(a_wb_rdata), .wb_out(a_wb_out), .wb_rd(a_wb_rd),
        .wb_data(a_wb_data), .wb_we(a_wb_we), .stall_cnt(a_cnt)
    );

    mem_wb_skid #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG_RO(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(b_mem_ready),
        .mem_regwrite(in_beat.regwrite), .mem_memtoreg(in_beat.memtoreg),
        .mem_rdata(in_beat.rdata), .mem_out(in_beat.out), .mem_rd(in_beat.rd),
        .wb_valid(b_wb_valid), .wb_ready(wb_ready),
        .wb_regwrite(b_wb_regwrite), .wb_memtoreg(b_wb_memtoreg),
        .wb_rdata(b_wb_rdata), .wb_out(b_wb_out), .wb_rd(b_wb_rd),
        .wb_data(b_wb_data), .wb_we(b_wb_we), .stall_cnt(b_cnt)
    );

    // Reference model: beats held at the boundary form an in-order queue of
    // at most two; the WB side shows the head (or the last head once empty).
    mem_wb_t q[$];
    mem_wb_t m_last  = '0;
    bit      m_ready = 1'b1;
    int      m_cnt_a = 0;
    int      m_cnt_b = 0;

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        q.delete();
        m_last  = '0;
        m_ready = 1'b1;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_edge();
        bit cons;
        bit acc;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            cons = (q.size() > 0) && wb_ready;
            acc  = mem_valid && m_ready;
            if ((q.size() > 0) && !wb_ready) begin
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 15)    m_cnt_b++;
            end
            if (cons) void'(q.pop_front());
            if (acc)  q.push_back(in_beat);
            m_ready = (q.size() < 2);
            if (q.size() > 0) m_last = q[0];
        end
    endtask

    function automatic logic exp_valid();
        return q.size() > 0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return m_last.memtoreg ? m_last.rdata : m_last.out;
    endfunction

    function automatic logic exp_we(bit zero_ro);
        return exp_valid() && m_last.regwrite && wb_ready && !(zero_ro && (m_last.rd == '0));
    endfunction

    function automatic mem_wb_t rand_beat();
        mem_wb_t b;
        b.regwrite = 1'($urandom);
        b.memtoreg = 1'($urandom);
        b.rdata    = DW'($urandom);
        b.out      = DW'($urandom);
        b.rd       = AW'($urandom);
        return b;
    endfunction

    function automatic mem_wb_t mk_beat(logic rw, logic m2r, logic [DW-1:0] rdata,
                                        logic [DW-1:0] out, logic [AW-1:0] rd);
        mem_wb_t b;
        b.regwrite = rw;
        b.memtoreg = m2r;
        b.rdata    = rdata;
        b.out      = out;
        b.rd       = rd;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'($urandom);
            wb_ready  = 1'($urandom);
            flush     = 1'($urandom);
            in_beat   = rand_beat();
            tick();
        end
        mem_valid = 1'b0;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        rst_n     = 1'b1;
        #1;
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", a_wb_valid); end
        checks++; if (a_wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", a_wb_data); end
        checks++; if (a_wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%b exp=0", a_wb_we); end
        checks++; if (a_mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got=%b exp=1", a_mem_ready); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt_a got=%0d exp=0", a_cnt); end
        checks++; if (b_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt_b got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_pass_through();
        wb_ready  = 1'b1;
        mem_valid = 1'b1;
        in_beat   = mk_beat(1'b1, 1'b1, 19'h1A5A5, 19'h15A5A, 3'd5);
        tick();
        checks++; if (a_wb_valid !== 1'b1) begin errors++; $display("FAIL pass1_valid got=%b exp=1", a_wb_valid); end
        checks++; if (a_wb_data !== 19'h1A5A5) begin errors++; $display("FAIL pass1_data got=%h exp=1a5a5", a_wb_data); end
        checks++; if (a_wb_we !== 1'b1) begin errors++; $display("FAIL pass1_we got=%b exp=1", a_wb_we); end
        checks++; if (a_wb_rd !== 3'd5) begin errors++; $display("FAIL pass1_rd got=%0d exp=5", a_wb_rd); end
        in_beat = mk_beat(1'b0, 1'b0, 19'h7FFFF, 19'h00000, 3'd2);
        tick();
        checks++; if (a_wb_data !== 19'h0) begin errors++; $display("FAIL pass2_data got=%h exp=0", a_wb_data); end
        checks++; if (a_wb_we !== 1'b0) begin errors++; $display("FAIL pass2_we got=%b exp=0", a_wb_we); end
        checks++; if (a_wb_rd !== 3'd2) begin errors++; $display("FAIL pass2_rd got=%0d exp=2", a_wb_rd); end
        mem_valid = 1'b0;
        tick();
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL pass_drain_valid got=%b exp=0", a_wb_valid); end
    endtask

    task automatic test_zero_reg();
        wb_ready  = 1'b1;
        mem_valid = 1'b1;
        in_beat   = mk_beat(1'b1, 1'b0, 19'h00011, 19'h00022, 3'd0);
        tick();
        mem_valid = 1'b0;
        checks++; if (b_wb_valid !== 1'b1) begin errors++; $display("FAIL zero_b_valid got=%b exp=1", b_wb_valid); end
        checks++; if (b_wb_we !== 1'b0) begin errors++; $display("FAIL zero_b_we got=%b exp=0", b_wb_we); end
        checks++; if (a_wb_we !== 1'b1) begin errors++; $display("FAIL zero_a_we got=%b exp=1", a_wb_we); end
        tick();
    endtask

    task automatic test_back_to_back();
        mem_wb_t ba, bb, bc;
        int      cnt0;
        ba = mk_beat(1'b1, 1'b0, 19'h00A0A, 19'h0AAAA, 3'd1);
        bb = mk_beat(1'b1, 1'b1, 19'h0BBBB, 19'h00B0B, 3'd3);
        bc = mk_beat(1'b0, 1'b0, 19'h00C0C, 19'h0CCCC, 3'd6);
        cnt0      = m_cnt_a;
        wb_ready  = 1'b0;
        mem_valid = 1'b1;
        in_beat   = ba; tick();
        in_beat   = bb; tick();
        checks++; if (a_mem_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got=%b exp=0", a_mem_ready); end
        in_beat   = bc; tick();
        tick();
        checks++; if (a_wb_rd !== 3'd1 || a_wb_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_a got rd=%0d v=%b exp rd=1 v=1", a_wb_rd, a_wb_valid); end
        checks++; if (a_cnt !== 16'(cnt0 + 3)) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", a_cnt, cnt0 + 3); end
        wb_ready = 1'b1;
        tick();
        checks++; if (a_wb_rd !== 3'd3 || a_wb_valid !== 1'b1) begin errors++; $display("FAIL bp_retire_b got rd=%0d v=%b exp rd=3 v=1", a_wb_rd, a_wb_valid); end
        tick();
        mem_valid = 1'b0;
        checks++; if (a_wb_data !== 19'h0CCCC || a_wb_valid !== 1'b1) begin errors++; $display("FAIL bp_retire_c got data=%h v=%b exp data=0cccc v=1", a_wb_data, a_wb_valid); end
        tick();
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", a_wb_valid); end
        checks++; if (a_cnt !== 16'(cnt0 + 3)) begin errors++; $display("FAIL bp_stall_final got=%0d exp=%0d", a_cnt, cnt0 + 3); end
    endtask

    task automatic test_flush();
        wb_ready  = 1'b0;
        mem_valid = 1'b1;
        in_beat   = rand_beat(); tick();
        in_beat   = rand_beat(); tick();
        in_beat   = rand_beat();
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", a_wb_valid); end
        checks++; if (a_mem_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", a_mem_ready); end
        checks++; if (a_cnt !== 16'(m_cnt_a)) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", a_cnt, m_cnt_a); end
        mem_valid = 1'b0;
        tick();
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", a_wb_valid); end
        checks++; if (a_wb_data !== exp_data()) begin errors++; $display("FAIL flush_payload_hold got=%h exp=%h", a_wb_data, exp_data()); end
    endtask

    task automatic test_saturation();
        wb_ready  = 1'b0;
        mem_valid = 1'b1;
        in_beat   = rand_beat();
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (b_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got=%0d exp=15", b_cnt); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (b_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", b_cnt); end
        checks++; if (a_cnt !== 16'(m_cnt_a)) begin errors++; $display("FAIL sat_cnt_a got=%0d exp=%0d", a_cnt, m_cnt_a); end
        wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            wb_ready  = ($urandom_range(0, 4) > 1);
            flush     = ($urandom_range(0, 19) == 0);
            in_beat   = rand_beat();
            #1;
            checks++; if (a_wb_valid !== exp_valid() || b_wb_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", i, a_wb_valid, b_wb_valid, exp_valid()); end
            checks++; if (a_mem_ready !== m_ready || b_mem_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", i, a_mem_ready, b_mem_ready, m_ready); end
            checks++; if ({a_wb_regwrite, a_wb_memtoreg, a_wb_rdata, a_wb_out, a_wb_rd} !== m_last) begin errors++; $display("FAIL rnd_payload_a cyc=%0d got=%h exp=%h", i, {a_wb_regwrite, a_wb_memtoreg, a_wb_rdata, a_wb_out, a_wb_rd}, m_last); end
            checks++; if ({b_wb_regwrite, b_wb_memtoreg, b_wb_rdata, b_wb_out, b_wb_rd} !== m_last) begin errors++; $display("FAIL rnd_payload_b cyc=%0d got=%h exp=%h", i, {b_wb_regwrite, b_wb_memtoreg, b_wb_rdata, b_wb_out, b_wb_rd}, m_last); end
            checks++; if (a_wb_data !== exp_data() || b_wb_data !== exp_data()) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h", i, a_wb_data, b_wb_data, exp_data()); end
            checks++; if (a_wb_we !== exp_we(1'b0) || b_wb_we !== exp_we(1'b1)) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b/%b exp=%b/%b", i, a_wb_we, b_wb_we, exp_we(1'b0), exp_we(1'b1)); end
            checks++; if (a_cnt !== 16'(m_cnt_a) || b_cnt !== 4'(m_cnt_b)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_cnt, b_cnt, m_cnt_a, m_cnt_b); end
            tick();
        end
        flush     = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        wb_ready  = 1'b0;
        mem_valid = 1'b1;
        in_beat   = rand_beat(); tick();
        in_beat   = rand_beat(); tick();
        mem_valid = 1'b0;
        checks++; if (a_mem_ready !== 1'b0 || a_wb_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got ready=%b v=%b exp ready=0 v=1", a_mem_ready, a_wb_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (a_wb_valid !== 1'b0 || b_wb_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b/%b exp=0", a_wb_valid, b_wb_valid); end
        checks++; if (a_mem_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b exp=1", a_mem_ready); end
        checks++; if (a_wb_data !== '0 || a_wb_we !== 1'b0) begin errors++; $display("FAIL areset_data got=%h we=%b exp=0", a_wb_data, a_wb_we); end
        checks++; if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin errors++; $display("FAIL areset_cnt got=%0d/%0d exp=0", a_cnt, b_cnt); end
        #2;
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        tick();
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL areset_after got=%b exp=0", a_wb_valid); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_zero_reg();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
Parametrised MEM→WB pipeline boundary for the 19-bit pipelined CPU. Replaces the plain MEM_WB register with a ready/valid handshake, a 2-entry skid buffer, synchronous flush and a built-in writeback data mux, so that writeback can back-pressure memory (multi-cycle register-file ports, future debug halt). It also keeps a saturating back-pressure cycle counter for performance monitoring.

Parameters:
DATA_W, 19, width of rdata/out/wb_data
REG_AW, 3, register address width (rd)
ZERO_REG_RO, 0, 1 = writes to rd==0 are suppressed on wb_we
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and incoming beats
mem_valid  in  1  MEM stage presents a beat
mem_ready  out  1  boundary can accept a beat
mem_regwrite  in  1  beat writes register file
mem_memtoreg  in  1  1 = writeback selects rdata, 0 = out
mem_rdata  in  DATA_W  data-memory read data
mem_out  in  DATA_W  ALU result
mem_rd  in  REG_AW  destination register
wb_valid  out  1  WB beat available
wb_ready  in  1  WB consumes beat this cycle
wb_regwrite  out  1  registered mem_regwrite
wb_memtoreg  out  1  registered mem_memtoreg
wb_rdata  out  DATA_W  registered rdata
wb_out  out  DATA_W  registered out
wb_rd  out  REG_AW  registered rd
wb_data  out  DATA_W  wb_memtoreg ? wb_rdata : wb_out (combinational from regs)
wb_we  out  1  register-file write strobe
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Storage: main entry (drives wb_*) and skid entry, each with a valid bit and a payload {regwrite, memtoreg, rdata, out, rd}.
- Reset (rst_n low, async): both valid bits 0, all payloads 0, stall_cnt 0. Hence wb_valid=0, wb_data=0, wb_we=0, mem_ready=1.
- mem_ready = !skid_valid, registered (no combinational path from wb_ready).
- accept = mem_valid & mem_ready; consume = wb_valid & wb_ready.
- Latency: an accepted beat appears on wb_* the next cycle when main is empty or consumed.
- Per cycle, in priority order:
  - flush=1: main_valid←0 and skid_valid←0; incoming beat dropped; payloads hold; stall_cnt unchanged.
  - skid full and consume: skid→main, skid_valid←0 (mem_ready is 0, so nothing is accepted).
  - main empty or consume: if accept, input→main, main_valid←1; otherwise main_valid←0 when consumed.
  - main full and not consume: if accept, input→skid, skid_valid←1 (mem_ready falls the next cycle).
- Order is preserved; no beat is lost or duplicated; at most 2 beats are held.
- wb_we = wb_valid & wb_regwrite & wb_ready & !(ZERO_REG_RO & (wb_rd==0)).
- stall_cnt increments when wb_valid & !wb_ready & !flush. It saturates at all-ones and does not wrap.
- Payload registers load only on capture. They hold when idle, so there is no toggling on bubbles.

Decomposition:
- Shared package cpu_pkg: DATA_W=19 and REG_AW=3 constants, plus a packed struct mem_wb_t {regwrite, memtoreg, rdata, out, rd} used for both entries and by EX_MEM successors.
- No sub-module is required. The skid buffer is generic enough to extract as pipe_skid (payload-width parameter) if reuse is wanted. mem_wb_skid then instantiates it and adds the mux, wb_we and the counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release → wb_valid=0, wb_data=0, wb_we=0, mem_ready=1, stall_cnt=0. Assert rst_n mid-stream with 2 beats held → all cleared immediately, without waiting for a clock edge.
- Pass-through: wb_ready=1; beat {regwrite=1, memtoreg=1, rdata=19'h1A5A5, out=19'h15A5A, rd=5} → next cycle wb_valid=1, wb_data=19'h1A5A5, wb_we=1, wb_rd=5. Next beat with memtoreg=0, out=19'h00000, rdata=19'h7FFFF, rd=2, regwrite=0 → wb_data=0, wb_we=0.
- Back-pressure: wb_ready=0, send beats A,B,C back-to-back → A in main, B in skid, mem_ready=0 the cycle after B, C not accepted. Raise wb_ready → A, B, C retire in order with no gaps. stall_cnt equals the number of wb_ready=0 cycles with wb_valid=1.
- Flush: with 2 beats held and mem_valid=1, pulse flush → next cycle wb_valid=0, mem_ready=1, the incoming beat is dropped, and stall_cnt is frozen.
- Zero register: ZERO_REG_RO=1, beat rd=0, regwrite=1, wb_ready=1 → wb_valid=1, wb_we=0. With ZERO_REG_RO=0 → wb_we=1.
- Saturation: CNT_W=4, hold wb_ready=0 with a beat held for 20 cycles → stall_cnt=15 and stays at 15.
